// File: rtl/mtimer_cmp_pkg.sv
// Shared definitions for the machine timer: register offsets, CTRL bit
// positions, the timer interrupt flag value and the address decoder.
package mtimer_cmp_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_PRESC    = 8'h04;
  localparam logic [7:0] OFF_MTIME_LO = 8'h08;
  localparam logic [7:0] OFF_MTIME_HI = 8'h0C;
  localparam logic [7:0] OFF_CMP_LO   = 8'h10;
  localparam logic [7:0] OFF_CMP_HI   = 8'h14;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_PEND_BIT   = 2;

  // Timer source flag on the interrupt controller's int_flag bus (cause 0x80000004)
  localparam logic [7:0] INT_TIMER_FLAG = 8'h01;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_PRESC,
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_NONE
  } reg_sel_e;

  // Word index is addr[7:2]; the byte lane bits never take part in decode.
  function automatic reg_sel_e decode_reg(input logic [5:0] word);
    reg_sel_e sel;
    sel = REG_NONE;
    if (word == OFF_CTRL[7:2])          sel = REG_CTRL;
    else if (word == OFF_PRESC[7:2])    sel = REG_PRESC;
    else if (word == OFF_MTIME_LO[7:2]) sel = REG_MTIME_LO;
    else if (word == OFF_MTIME_HI[7:2]) sel = REG_MTIME_HI;
    else if (word == OFF_CMP_LO[7:2])   sel = REG_CMP_LO;
    else if (word == OFF_CMP_HI[7:2])   sel = REG_CMP_HI;
    return sel;
  endfunction

endpackage

// File: rtl/mtimer_cmp_presc.sv
// Prescaler down-counter: ticks when the count reaches zero and reloads,
// so an enabled timer advances once every reload+1 cycles.
module mtimer_cmp_presc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] reload_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  // A new reload value takes effect immediately, even in a tick cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (!en_i || tick_o)
      cnt_d = reload_i;
    else
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mtimer_cmp.sv
// Memory-mapped machine timer: prescaled 64-bit mtime, 64-bit compare and a
// sticky pending bit driving the timer line of the interrupt controller.
module mtimer_cmp
  import mtimer_cmp_pkg::*;
#(
  parameter int PRESC_W = 16,
  parameter int INT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [7:0]       addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  output logic [INT_W-1:0] int_flag_o
);

  reg_sel_e sel;
  logic     unused_addr_lane;

  logic               en_q, en_d;
  logic               irq_en_q, irq_en_d;
  logic               pend_q, pend_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        cmp_q, cmp_d;
  logic [31:0]        shadow_q, shadow_d;

  logic tick;
  logic hit;
  logic wr_ctrl, wr_presc, wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;

  assign sel              = decode_reg(addr_i[7:2]);
  assign unused_addr_lane = ^addr_i[1:0];

  assign wr_ctrl     = we_i && (sel == REG_CTRL);
  assign wr_presc    = we_i && (sel == REG_PRESC);
  assign wr_mtime_lo = we_i && (sel == REG_MTIME_LO);
  assign wr_mtime_hi = we_i && (sel == REG_MTIME_HI);
  assign wr_cmp_lo   = we_i && (sel == REG_CMP_LO);
  assign wr_cmp_hi   = we_i && (sel == REG_CMP_HI);

  mtimer_cmp_presc #(
    .W (PRESC_W)
  ) u_presc (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_q),
    .reload_i   (presc_q),
    .load_i     (wr_presc),
    .load_val_i (data_i[PRESC_W-1:0]),
    .tick_o     (tick)
  );

  assign hit = en_q && (mtime_q >= cmp_q);

  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    if (wr_ctrl) begin
      en_d     = data_i[CTRL_EN_BIT];
      irq_en_d = data_i[CTRL_IRQ_EN_BIT];
    end
  end

  // A compare hit in the same cycle as a W1C keeps PEND set.
  always_comb begin
    pend_d = pend_q;
    if (wr_ctrl && data_i[CTRL_PEND_BIT])
      pend_d = 1'b0;
    if (hit)
      pend_d = 1'b1;
  end

  assign presc_d = wr_presc ? data_i[PRESC_W-1:0] : presc_q;

  // Bus writes to either half win over the tick; the other half is kept.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime_lo)
      mtime_d[31:0] = data_i;
    else if (wr_mtime_hi)
      mtime_d[63:32] = data_i;
    else if (tick)
      mtime_d = mtime_q + 64'd1;
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp_lo)
      cmp_d[31:0] = data_i;
    if (wr_cmp_hi)
      cmp_d[63:32] = data_i;
  end

  // A LO read freezes the matching HI half so a following HI read is coherent.
  assign shadow_d = (re_i && (sel == REG_MTIME_LO)) ? mtime_q[63:32] : shadow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      pend_q   <= 1'b0;
      presc_q  <= '0;
      mtime_q  <= '0;
      cmp_q    <= {CMP_RESET, CMP_RESET};
      shadow_q <= '0;
    end else begin
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
      presc_q  <= presc_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    data_o = '0;
    case (sel)
      REG_CTRL: begin
        data_o[CTRL_EN_BIT]     = en_q;
        data_o[CTRL_IRQ_EN_BIT] = irq_en_q;
        data_o[CTRL_PEND_BIT]   = pend_q;
      end
      REG_PRESC:    data_o = 32'(presc_q);
      REG_MTIME_LO: data_o = mtime_q[31:0];
      REG_MTIME_HI: data_o = shadow_q;
      REG_CMP_LO:   data_o = cmp_q[31:0];
      REG_CMP_HI:   data_o = cmp_q[63:32];
      default:      data_o = '0;
    endcase
  end

  assign int_flag_o = (pend_q && irq_en_q) ? INT_W'(INT_TIMER_FLAG) : '0;

endmodule
